// File: rtl/fifo_share_ctrl.sv
// Shares one synchronous block-RAM FIFO primitive between N round-robin writers and
// presents its non-FWFT read port as a valid/ready stream through a 2-entry skid buffer.
module fifo_share_ctrl #(
  parameter int N        = 4,
  parameter int W        = 9,
  parameter int DEPTH    = 2048,
  parameter int RST_CYC  = 5,
  parameter int WAIT_CYC = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic [N-1:0]                 req_valid,
  input  logic [N*W-1:0]               req_data,
  output logic [N-1:0]                 req_ready,
  output logic                         out_valid,
  output logic [W-1:0]                 out_data,
  input  logic                         out_ready,
  output logic                         fifo_rst,
  output logic [W-1:0]                 fifo_din,
  output logic                         fifo_wr_en,
  output logic                         fifo_rd_en,
  input  logic [W-1:0]                 fifo_dout,
  input  logic                         fifo_empty,
  input  logic                         fifo_wrerr,
  input  logic                         fifo_rderr,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         err
);

  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (N > 1) ? $clog2(N) : 1;
  localparam int CYC_MAX = (RST_CYC > WAIT_CYC) ? RST_CYC : WAIT_CYC;
  localparam int CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  typedef enum logic [1:0] {
    ST_RST_ASSERT = 2'd0,
    ST_WAIT       = 2'd1,
    ST_RUN        = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_gnt_idx;
  logic [PTR_W-1:0] w_cand;
  logic             w_gnt_any;
  logic [N-1:0]     w_grant;
  logic             w_run;
  logic             w_space;

  logic [OCC_W-1:0] r_occ;
  logic             r_vld_p1;
  logic             w_rd_en;
  logic             w_pop;
  logic [2:0]       w_skid_lvl;
  logic [W-1:0]     r_skid_mem [2];
  logic             r_skid_wp;
  logic             r_skid_rp;
  logic [1:0]       r_skid_cnt;
  logic             r_err;

  // Modulo-N add for the round-robin pointer; off is at most N.
  function automatic logic [PTR_W-1:0] f_ptr_add(input logic [PTR_W-1:0] base, input int off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(off);
    if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_RST_ASSERT: begin
        if (r_cnt == CNT_W'(RST_CYC - 1)) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_W'(WAIT_CYC - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_state <= ST_RST_ASSERT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_run    = (r_state == ST_RUN);
  assign fifo_rst = (r_state == ST_RST_ASSERT);
  assign busy     = !w_run;
  assign w_space  = (r_occ < OCC_W'(DEPTH));

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    w_cand    = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = f_ptr_add(r_ptr, k);
      if (!w_gnt_any && w_run && w_space && req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
  end

  assign req_ready  = w_grant;
  assign fifo_wr_en = w_gnt_any;
  assign fifo_din   = req_data[int'(w_gnt_idx)*W +: W];

  // Stage p0: issue a read only if the skid can absorb it once this cycle's pop is counted.
  assign out_valid  = (r_skid_cnt != 2'd0);
  assign out_data   = r_skid_mem[r_skid_rp];
  assign w_pop      = out_valid && out_ready;
  assign w_skid_lvl = {1'b0, r_skid_cnt} - {2'b00, w_pop} + {2'b00, r_vld_p1};
  assign w_rd_en    = w_run && !fifo_empty && (r_occ != '0) && (w_skid_lvl < 3'd2);
  assign fifo_rd_en = w_rd_en;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_ptr      <= '0;
      r_occ      <= '0;
      r_vld_p1   <= 1'b0;
      r_skid_wp  <= 1'b0;
      r_skid_rp  <= 1'b0;
      r_skid_cnt <= 2'd0;
      r_err      <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_en;
      if (w_gnt_any) r_ptr <= f_ptr_add(w_gnt_idx, 1);
      if (w_gnt_any && !w_rd_en)      r_occ <= r_occ + 1'b1;
      else if (!w_gnt_any && w_rd_en) r_occ <= r_occ - 1'b1;
      if (r_vld_p1) r_skid_wp <= !r_skid_wp;
      if (w_pop)    r_skid_rp <= !r_skid_rp;
      r_skid_cnt <= r_skid_cnt + {1'b0, r_vld_p1} - {1'b0, w_pop};
      if (w_run && (fifo_wrerr || fifo_rderr)) r_err <= 1'b1;
    end
  end

  // Stage p1: primitive read data is valid now and lands in the skid buffer.
  always_ff @(posedge clk) begin
    if (r_vld_p1) r_skid_mem[r_skid_wp] <= fifo_dout;
  end

  assign occupancy = r_occ;
  assign err       = r_err;

endmodule
